line_clear_engine: RTL and testbench

// - Hardware line-clear stage upstream of the VGA Avalon display block.
// - On start, scans the 20 board-row words (bits[19:0] = 10 cells x 2b) in the display RAM, bottom to top.
// - Removes full rows and shifts the rows above them down, then fills the vacated top rows with empty words.
// - Updates the BCD lines/level counters and writes {level,lines} to the level/lines word that the display renders.

---
 rtl/line_clear_if.sv | 35 +++
 rtl/line_clear_engine.sv | 196 +++++++++++++++++++
 tb/tb_line_clear_engine.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/line_clear_if.sv
// Bundle between the line-clear engine and its controller/RAM port.
// Control handshake: start and load_level are single-cycle requests that
// are only honoured while the engine is idle (busy=0, done=0); done is a
// single-cycle completion pulse and busy drops in that same cycle.
// RAM port: mem_rd and mem_wr are one-cycle strobes qualified by mem_addr;
// read data must be presented on mem_rdata exactly one cycle after mem_rd.
// state_dbg mirrors the engine's FSM state register for observation.
interface line_clear_if;
    logic        start;
    logic        load_level;
    logic [15:0] level_init;
    logic        busy;
    logic        done;
    logic [2:0]  cleared;
    logic [15:0] lines_bcd;
    logic [15:0] level_bcd;
    logic [10:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [2:0]  state_dbg;

    modport slave (
        input  start, load_level, level_init, mem_rdata,
        output busy, done, cleared, lines_bcd, level_bcd,
               mem_addr, mem_rd, mem_wr, mem_wdata, state_dbg
    );

    modport master (
        output start, load_level, level_init, mem_rdata,
        input  busy, done, cleared, lines_bcd, level_bcd,
               mem_addr, mem_rd, mem_wr, mem_wdata, state_dbg
    );
endinterface

// File: rtl/line_clear_engine.sv
// Line-clear engine: scans the 20 board rows bottom-to-top, drops full
// rows, compacts the rest downwards, blanks the vacated top rows and then
// writes the updated {level, lines} BCD word for the display.
// Optional feature macro: LEVEL_AUTO_EN -- when defined, the level counter
// advances by one each time a pass carries lines_bcd across a tens boundary.
module line_clear_engine (
    input  logic          CLK,
    input  logic          RESET,
    line_clear_if.slave   bus
);
    localparam int          ROWS       = 20;
    localparam logic [10:0] ROW0_ADDR  = 11'h002;
    localparam logic [10:0] LL_ADDR    = 11'h000;
    localparam logic [1:0]  EMPTY_CODE = 2'b00;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_EVAL = 3'd3;
    localparam logic [2:0] S_FILL = 3'd4;
    localparam logic [2:0] S_WB   = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    logic [2:0]  state;
    logic [4:0]  src;        // row being examined
    logic [4:0]  dst;        // next row slot to be written
    logic [4:0]  full_cnt;   // true number of full rows (up to 20); drives FILL length
    logic [31:0] row_q;      // captured row word
    logic [15:0] lines_q;
    logic [15:0] level_q;
    logic [2:0]  cleared_q;

    logic        row_full;
    logic [4:0]  full_cnt_nxt;
    logic [2:0]  cnt_sat;
    logic [15:0] lines_next;
    logic [15:0] level_next;

    // Four-digit BCD add of a small increment with per-digit carry; an
    // overflow out of the top digit clamps the result to 9999.
    function automatic logic [15:0] bcd_add_sat(input logic [15:0] a, input logic [2:0] inc);
        logic [15:0] r;
        logic [4:0]  d;
        logic [4:0]  c;
        r = '0;
        c = {2'b00, inc};
        for (int i = 0; i < 4; i++) begin
            d = {1'b0, a[4*i +: 4]} + c;
            if (d > 5'd9) begin
                d = d - 5'd10;
                c = 5'd1;
            end else begin
                c = 5'd0;
            end
            r[4*i +: 4] = d[3:0];
        end
        if (c != 5'd0) begin
            r = 16'h9999;
        end
        return r;
    endfunction

    // A row is full when none of its ten 2-bit cells holds the empty code.
    always_comb begin
        row_full = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (row_q[2*i +: 2] == EMPTY_CODE) begin
                row_full = 1'b0;
            end
        end
    end

    // Counter arithmetic for the write-back: saturated clear count and new BCD values.
    always_comb begin
        full_cnt_nxt = full_cnt + {4'd0, row_full};
        cnt_sat      = (full_cnt > 5'd4) ? 3'd4 : full_cnt[2:0];
        lines_next   = bcd_add_sat(lines_q, cnt_sat);
`ifdef LEVEL_AUTO_EN
        // Increments are at most 4, so at most one tens boundary is crossed.
        level_next   = (lines_next[15:4] != lines_q[15:4]) ? bcd_add_sat(level_q, 3'd1) : level_q;
`else
        level_next   = level_q;
`endif
    end

    // RAM strobes, address and data decoded from the current state.
    always_comb begin
        bus.mem_rd    = 1'b0;
        bus.mem_wr    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        case (state)
            S_RD: begin
                bus.mem_rd   = 1'b1;
                bus.mem_addr = ROW0_ADDR + {6'd0, src};
            end
            S_EVAL: begin
                // Rows that stay put are not rewritten.
                if (!row_full && (dst != src)) begin
                    bus.mem_wr    = 1'b1;
                    bus.mem_addr  = ROW0_ADDR + {6'd0, dst};
                    bus.mem_wdata = row_q;
                end
            end
            S_FILL: begin
                bus.mem_wr    = 1'b1;
                bus.mem_addr  = ROW0_ADDR + {6'd0, dst};
                bus.mem_wdata = 32'h0;
            end
            S_WB: begin
                bus.mem_wr    = 1'b1;
                bus.mem_addr  = LL_ADDR;
                bus.mem_wdata = {level_next, lines_next};
            end
            default: begin
            end
        endcase
    end

    // Status outputs follow the state register and committed counters.
    always_comb begin
        bus.busy      = (state != S_IDLE) && (state != S_DONE);
        bus.done      = (state == S_DONE);
        bus.cleared   = cleared_q;
        bus.lines_bcd = lines_q;
        bus.level_bcd = level_q;
        bus.state_dbg = state;
    end

    // Pass sequencer: read/wait/evaluate per row, blank-fill, write-back, done.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= S_IDLE;
            src       <= '0;
            dst       <= '0;
            full_cnt  <= '0;
            row_q     <= '0;
            lines_q   <= '0;
            level_q   <= '0;
            cleared_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.load_level) begin
                        level_q <= bus.level_init;
                        lines_q <= '0;
                    end
                    if (bus.start) begin
                        src      <= 5'(ROWS - 1);
                        dst      <= 5'(ROWS - 1);
                        full_cnt <= '0;
                        state    <= S_RD;
                    end
                end
                S_RD: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    row_q <= bus.mem_rdata;
                    state <= S_EVAL;
                end
                S_EVAL: begin
                    full_cnt <= full_cnt_nxt;
                    if (!row_full) begin
                        dst <= dst - 5'd1;
                    end
                    if (src == 5'd0) begin
                        state <= (full_cnt_nxt != 5'd0) ? S_FILL : S_WB;
                    end else begin
                        src   <= src - 5'd1;
                        state <= S_RD;
                    end
                end
                S_FILL: begin
                    // dst counts down to row 0, giving one blank row per removed row.
                    dst <= dst - 5'd1;
                    if (dst == 5'd0) begin
                        state <= S_WB;
                    end
                end
                S_WB: begin
                    lines_q   <= lines_next;
                    level_q   <= level_next;
                    cleared_q <= cnt_sat;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_line_clear_engine.sv
// Bench for line_clear_engine: a RAM model serves the engine, the driver
// launches directed and random passes and pushes the reference result of
// each pass into exp_q; the monitor pops and compares on every done pulse.
module tb_line_clear_engine;
    typedef struct packed {
        logic [19:0][31:0] rows;
        logic [2:0]        cleared;
        logic [15:0]       lines;
        logic [15:0]       level;
        logic [15:0]       writes;
        logic [31:0]       done_cyc;
    } exp_t;

    logic CLK;
    logic RESET;
    line_clear_if bus();

    line_clear_engine dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    logic [31:0]       ram [0:31];
    logic [19:0][31:0] bd_rows;
    logic              bd_go;
    int                cyc;
    int                wr_cnt;
    int                ovl_cnt;
    int                wr_base;
    int                total;
    int                bad;
    int                m_lines;
    int                m_level;
    exp_t              exp_q[$];

    // Clock and cycle counter
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) begin
        cyc <= cyc + 1;
    end

    // RAM model: one-cycle read latency, backdoor row preload from the driver
    always @(posedge CLK) begin
        if (bd_go) begin
            for (int r = 0; r < 20; r++) ram[2 + r] <= bd_rows[r];
        end
        if (bus.mem_rd) bus.mem_rdata <= ram[bus.mem_addr[4:0]];
        if (bus.mem_wr) begin
            ram[bus.mem_addr[4:0]] <= bus.mem_wdata;
            wr_cnt <= wr_cnt + 1;
        end
        if (bus.mem_rd && bus.mem_wr) ovl_cnt <= ovl_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int bcd2int(input logic [15:0] b);
        return int'(b[15:12]) * 1000 + int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [15:0] int2bcd(input int v);
        logic [15:0] b;
        b[15:12] = 4'((v / 1000) % 10);
        b[11:8]  = 4'((v / 100) % 10);
        b[7:4]   = 4'((v / 10) % 10);
        b[3:0]   = 4'(v % 10);
        return b;
    endfunction

    function automatic bit is_full(input logic [31:0] w);
        for (int i = 0; i < 10; i++) begin
            if (((w >> (2 * i)) & 32'd3) == 32'd0) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [31:0] gen_row(input bit full);
        logic [31:0] w;
        logic [1:0]  f;
        w = {12'($urandom_range(0, 4095)), 20'h0};
        for (int i = 0; i < 10; i++) begin
            f = full ? 2'($urandom_range(1, 3)) : 2'($urandom_range(0, 3));
            w[2*i +: 2] = f;
        end
        if (!full) w[2*$urandom_range(0, 9) +: 2] = 2'b00;
        return w;
    endfunction

    // Reference: surviving rows keep their bottom-to-top order and settle at the bottom.
    function automatic exp_t model_pass(input logic [19:0][31:0] rows, input int cyc0);
        exp_t e;
        int   keep[$];
        int   f;
        int   moved;
        int   csat;
        int   old;
        f = 0;
        moved = 0;
        for (int i = 19; i >= 0; i--) begin
            if (is_full(rows[i])) f++;
            else keep.push_back(i);
        end
        e.rows = '0;
        for (int k = 0; k < keep.size(); k++) begin
            e.rows[19 - k] = rows[keep[k]];
            if (keep[k] != 19 - k) moved++;
        end
        csat = (f > 4) ? 4 : f;
        old = m_lines;
        m_lines = (old + csat > 9999) ? 9999 : old + csat;
`ifdef LEVEL_AUTO_EN
        if (m_lines / 10 != old / 10) m_level = (m_level >= 9999) ? 9999 : m_level + 1;
`endif
        e.cleared  = 3'(csat);
        e.lines    = int2bcd(m_lines);
        e.level    = int2bcd(m_level);
        e.writes   = 16'(moved + f + 1);
        e.done_cyc = 32'(cyc0 + 62 + f);
        return e;
    endfunction

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge CLK);
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending passes expected 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge CLK);
    endtask

    task automatic run_pass(input logic [19:0][31:0] rows, input bit do_load,
                            input logic [15:0] lvl, input bit extra);
        @(negedge CLK);
        bd_rows = rows;
        bd_go = 1'b1;
        @(negedge CLK);
        bd_go = 1'b0;
        if (do_load) begin
            bus.load_level = 1'b1;
            bus.level_init = lvl;
            m_level = bcd2int(lvl);
            m_lines = 0;
        end
        bus.start = 1'b1;
        exp_q.push_back(model_pass(rows, cyc));
        @(negedge CLK);
        bus.start = 1'b0;
        bus.load_level = 1'b0;
        if (extra) begin
            repeat ($urandom_range(5, 50)) @(negedge CLK);
            bus.start = 1'b1;
            bus.load_level = 1'($urandom_range(0, 1));
            bus.level_init = int2bcd($urandom_range(0, 9999));
            @(negedge CLK);
            bus.start = 1'b0;
            bus.load_level = 1'b0;
        end
        wait_drain();
    endtask

    // Monitor: on each done pulse, compare against the oldest expected pass
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (RESET) begin
                wr_base = wr_cnt;
            end else if (bus.done) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got done=1 expected no pass in flight");
                end else begin
                    e = exp_q.pop_front();
                    chk("cleared", 32'(bus.cleared), 32'(e.cleared));
                    chk("lines_bcd", 32'(bus.lines_bcd), 32'(e.lines));
                    chk("level_bcd", 32'(bus.level_bcd), 32'(e.level));
                    chk("ll_word", ram[0], {e.level, e.lines});
                    chk("busy_at_done", 32'(bus.busy), 32'd0);
                    chk("pass_cycles", 32'(cyc), e.done_cyc);
                    chk("write_count", 32'(wr_cnt - wr_base), 32'(e.writes));
                    for (int r = 0; r < 20; r++) chk($sformatf("row%0d", r), ram[2 + r], e.rows[r]);
                end
                wr_base = wr_cnt;
            end
        end
    end

    // Stimulus
    initial begin
        logic [19:0][31:0] rows;
        int wsnap;
        total = 0; bad = 0; m_lines = 0; m_level = 0;
        cyc = 0; wr_cnt = 0; ovl_cnt = 0; wr_base = 0;
        bd_go = 1'b0; bd_rows = '0;
        bus.start = 1'b0; bus.load_level = 1'b0; bus.level_init = '0;
        RESET = 1'b1;
        repeat (3) @(negedge CLK);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_cleared", 32'(bus.cleared), 32'd0);
        chk("rst_lines", 32'(bus.lines_bcd), 32'd0);
        chk("rst_level", 32'(bus.level_bcd), 32'd0);
        chk("rst_rd_wr", {30'd0, bus.mem_rd, bus.mem_wr}, 32'd0);
        chk("rst_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_wdata", bus.mem_wdata, 32'd0);
        RESET = 1'b0;

        // Single full bottom row
        rows = '0; rows[19] = 32'h000FFFFF;
        run_pass(rows, 1'b0, 16'h0, 1'b0);
        // Four full rows under a partial row
        rows = '0; rows[15] = 32'h00000155;
        for (int r = 16; r < 20; r++) rows[r] = gen_row(1'b1);
        run_pass(rows, 1'b0, 16'h0, 1'b0);
        // Partial row with upper bits between two full rows
        rows = '0; rows[17] = gen_row(1'b1); rows[18] = 32'h00100003; rows[19] = 32'h000FFFFF;
        run_pass(rows, 1'b0, 16'h0, 1'b0);

        // Level 3 loaded with the start, lines brought to 9, then one more row
        rows = '0;
        for (int r = 16; r < 20; r++) rows[r] = gen_row(1'b1);
        run_pass(rows, 1'b1, 16'h0003, 1'b0);
        run_pass(rows, 1'b0, 16'h0, 1'b0);
        rows = '0; rows[19] = gen_row(1'b1);
        run_pass(rows, 1'b0, 16'h0, 1'b0);
        run_pass(rows, 1'b0, 16'h0, 1'b0);
        chk("lines_9_to_10", 32'(bus.lines_bcd), 32'h0010);
`ifdef LEVEL_AUTO_EN
        chk("level_after_10", 32'(bus.level_bcd), 32'h0004);
`else
        chk("level_after_10", 32'(bus.level_bcd), 32'h0003);
`endif

        // No full rows: only the level/lines word is written
        for (int r = 0; r < 20; r++) rows[r] = gen_row(1'b0);
        run_pass(rows, 1'b0, 16'h0, 1'b0);
        // Entire board full
        for (int r = 0; r < 20; r++) rows[r] = gen_row(1'b1);
        run_pass(rows, 1'b0, 16'h0, 1'b0);
        // Level saturation at 9999 across a tens boundary
        rows = '0;
        for (int r = 16; r < 20; r++) rows[r] = gen_row(1'b1);
        run_pass(rows, 1'b1, 16'h9999, 1'b0);
        run_pass(rows, 1'b0, 16'h0, 1'b0);
        run_pass(rows, 1'b0, 16'h0, 1'b0);

        // Reset in cycle 10 of a pass aborts it
        for (int r = 0; r < 20; r++) rows[r] = gen_row(r % 3 == 0);
        @(negedge CLK);
        bd_rows = rows; bd_go = 1'b1;
        @(negedge CLK);
        bd_go = 1'b0; bus.start = 1'b1;
        @(negedge CLK);
        bus.start = 1'b0;
        repeat (9) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_lines", 32'(bus.lines_bcd), 32'd0);
        chk("abort_level", 32'(bus.level_bcd), 32'd0);
        chk("abort_wr", 32'(bus.mem_wr), 32'd0);
        RESET = 1'b0;
        m_lines = 0; m_level = 0;
        wsnap = wr_cnt;
        repeat (80) @(negedge CLK);
        chk("abort_no_writes", 32'(wr_cnt), 32'(wsnap));

        // Random passes, some with stray start/load_level while busy
        for (int p = 0; p < 30; p++) begin
            for (int r = 0; r < 20; r++) rows[r] = gen_row($urandom_range(0, 3) == 0);
            run_pass(rows, $urandom_range(0, 5) == 0, int2bcd($urandom_range(0, 9999)),
                     $urandom_range(0, 2) == 0);
        end

        chk("rd_wr_overlap", 32'(ovl_cnt), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
